// File: rtl/mdu_riscv.sv
// MDU_RISCV: iterative RISC-V M-extension multiply/divide unit, one result bit per cycle.
// Optional macro MDU_EARLY_OUT_EN: zero-operand multiplies and small unsigned divides finish one edge after accept.
//
// state | meaning
// IDLE  | ready to accept a request
// CALC  | iterating, or resolving a special case on the first cycle
// DONE  | result held on result_o/dz_o until ready_i
module mdu_riscv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            kill_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            dz_o
);
    localparam int CW = $clog2(XLEN + 1);
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;
    localparam logic [XLEN-1:0]   ONE  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE2 = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MINV = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CW-1:0]     cnt_q;

    function automatic logic sgn_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic sgn_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
        return (s && x[XLEN-1]) ? (~x + ONE) : x;
    endfunction

    logic              is_div, a_neg, b_neg, accept;
    logic [XLEN-1:0]   mb, quo, rem, fin_res, spec_res;
    logic              spec_hit, spec_dz;
    logic [XLEN:0]     mul_sum, div_sh, div_sub;
    logic [2*XLEN-1:0] mul_next, div_next, prod;

    assign is_div = op_q[2];
    assign a_neg  = sgn_a(op_q) & a_q[XLEN-1];
    assign b_neg  = sgn_b(op_q) & b_q[XLEN-1];
    assign mb     = mag(b_q, sgn_b(op_q));

    // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mb : {XLEN{1'b0}})};
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign div_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_sub  = div_sh - {1'b0, mb};
    assign div_next = div_sub[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod = (a_neg ^ b_neg) ? (~acc_q + ONE2) : acc_q;
    assign quo  = (a_neg ^ b_neg) ? (~acc_q[XLEN-1:0] + ONE) : acc_q[XLEN-1:0];
    assign rem  = a_neg ? (~acc_q[2*XLEN-1:XLEN] + ONE) : acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fin_res = '0;
        case (op_q)
            OP_MUL:                        fin_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fin_res = quo;
            OP_REM, OP_REMU:               fin_res = rem;
            default:                       fin_res = '0;
        endcase
    end

    // op_q[1] selects remainder, op_q[0] unsigned, among divide ops
    always_comb begin
        spec_hit = 1'b0;
        spec_res = '0;
        spec_dz  = 1'b0;
        if (is_div && (b_q == '0)) begin
            spec_hit = 1'b1;
            spec_dz  = 1'b1;
            spec_res = op_q[1] ? a_q : '1;
        end else if (is_div && !op_q[0] && (a_q == MINV) && (b_q == '1)) begin
            spec_hit = 1'b1;
            spec_res = op_q[1] ? '0 : a_q;
        end
`ifdef MDU_EARLY_OUT_EN
        else if (!is_div && ((a_q == '0) || (b_q == '0))) begin
            spec_hit = 1'b1;
        end else if (is_div && op_q[0] && (a_q < b_q)) begin
            spec_hit = 1'b1;
            spec_res = op_q[1] ? a_q : '0;
        end
`endif
    end

    assign accept = (state_q == IDLE) && valid_i && !kill_i;

    always_comb begin
        state_d = state_q;
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
        case (state_q)
            IDLE:    if (accept) state_d = CALC;
            CALC:    if (spec_hit || (cnt_q == '0)) state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_o <= '0;
            dz_o     <= 1'b0;
        end else if (accept) begin
            op_q  <= op_i;
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= {{XLEN{1'b0}}, mag(a_i, sgn_a(op_i))};
            cnt_q <= CW'(XLEN);
        end else if ((state_q == CALC) && !kill_i) begin
            if (spec_hit) begin
                result_o <= spec_res;
                dz_o     <= spec_dz;
            end else if (cnt_q == '0) begin
                result_o <= fin_res;
                dz_o     <= 1'b0;
            end else begin
                acc_q <= is_div ? div_next : mul_next;
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mdu_riscv.sv
// Directed bench for mdu_riscv: scoreboard of expected results, latency, backpressure, kill and reset.
module tb_mdu_riscv;
    localparam int XLEN = 32;
`ifdef MDU_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = XLEN + 1;
`endif
    localparam int FULL = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst_n, valid_i, ready_o, kill_i, valid_o, ready_i, dz_o;
    logic [2:0]      op_i;
    logic [XLEN-1:0] a_i, b_i, result_o;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            dz;
        int              lat;
    } exp_t;
    exp_t sb[$];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mdu_riscv #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .kill_i(kill_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o), .dz_o(dz_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // called just after a negedge with the unit idle; returns at the negedge where valid_o is seen
    task automatic do_op(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] res,
                         input logic dz, input int lat);
        exp_t e;
        int   n;
        e.res = res; e.dz = dz; e.lat = lat;
        sb.push_back(e);
        chk({tag, "/ready_before"}, 64'(ready_o), 64'd1);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0; op_i = ~op; a_i = ~a; b_i = $urandom;
        n = 0;
        while (!valid_o && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({tag, "/latency"}, 64'(n), 64'(e.lat));
        chk({tag, "/result"}, 64'(result_o), 64'(e.res));
        chk({tag, "/dz"}, 64'(dz_o), 64'(e.dz));
        chk({tag, "/ready_busy"}, 64'(ready_o), 64'd0);
    endtask

    task automatic consume(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "/valid_after"}, 64'(valid_o), 64'd0);
        chk({tag, "/ready_after"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; valid_i = 1'b0; kill_i = 1'b0; ready_i = 1'b1;
        op_i = '0; a_i = '0; b_i = '0;
        #12;
        chk("rst/ready", 64'(ready_o), 64'd1);
        chk("rst/valid", 64'(valid_o), 64'd0);
        chk("rst/result", 64'(result_o), 64'd0);
        chk("rst/dz", 64'(dz_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mul",    3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, FULL); consume("mul");
        do_op("mulh",   3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, FULL); consume("mulh");
        do_op("mulhu",  3'd3, 32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0, FULL); consume("mulhu");
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, FULL); consume("mulhsu");
        do_op("mulhu2", 3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0, FULL); consume("mulhu2");

        do_op("div",    3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0, FULL); consume("div");
        do_op("rem",    3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0, FULL); consume("rem");
        do_op("divu",   3'd5, 32'd20, 32'd3, 32'd6, 1'b0, FULL); consume("divu");
        do_op("remu",   3'd7, 32'd20, 32'd3, 32'd2, 1'b0, FULL); consume("remu");

        do_op("div_dz",  3'd4, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1'b1, 1); consume("div_dz");
        do_op("remu_dz", 3'd7, 32'h0000_1234, 32'h0, 32'h0000_1234, 1'b1, 1); consume("remu_dz");
        do_op("divu_dz", 3'd5, 32'h0000_1234, 32'h0, 32'hFFFF_FFFF, 1'b1, 1); consume("divu_dz");
        do_op("rem_dz",  3'd6, 32'h0000_1234, 32'h0, 32'h0000_1234, 1'b1, 1); consume("rem_dz");

        do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1); consume("div_ovf");
        do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1); consume("rem_ovf");

        do_op("mul_zero", 3'd0, 32'h0, 32'd5, 32'h0, 1'b0, EO_LAT); consume("mul_zero");
        do_op("divu_lt",  3'd5, 32'd3, 32'd10, 32'd0, 1'b0, EO_LAT); consume("divu_lt");
        do_op("remu_lt",  3'd7, 32'd3, 32'd10, 32'd3, 1'b0, EO_LAT); consume("remu_lt");

        // backpressure: result must hold while the consumer stalls
        ready_i = 1'b0;
        do_op("bp", 3'd0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340, 1'b0, FULL);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp/valid_hold", 64'(valid_o), 64'd1);
            chk("bp/result_hold", 64'(result_o), 64'h1_2340);
            chk("bp/ready_low", 64'(ready_o), 64'd0);
        end
        ready_i = 1'b1;
        consume("bp");

        // kill beats valid in IDLE
        valid_i = 1'b1; kill_i = 1'b1; op_i = 3'd0; a_i = 32'd5; b_i = 32'd6;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0; kill_i = 1'b0;
        chk("kill_idle/ready", 64'(ready_o), 64'd1);

        // kill mid-CALC on the tenth edge after accept
        valid_i = 1'b1; op_i = 3'd0; a_i = 32'd5; b_i = 32'd6;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("kill/busy", 64'(ready_o), 64'd0);
        kill_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        kill_i = 1'b0;
        chk("kill/valid", 64'(valid_o), 64'd0);
        chk("kill/ready", 64'(ready_o), 64'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) seen++;
        end
        chk("kill/no_valid", 64'(seen), 64'd0);
        do_op("after_kill", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, FULL); consume("after_kill");

        // async reset mid-CALC, with nonzero result/dz left from the previous op
        do_op("pre_rst", 3'd7, 32'h0000_1234, 32'h0, 32'h0000_1234, 1'b1, 1); consume("pre_rst");
        valid_i = 1'b1; op_i = 3'd0; a_i = 32'h55; b_i = 32'h3;
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_calc/ready", 64'(ready_o), 64'd1);
        chk("rst_calc/valid", 64'(valid_o), 64'd0);
        chk("rst_calc/result", 64'(result_o), 64'd0);
        chk("rst_calc/dz", 64'(dz_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("post_rst_mul0", 3'd0, 32'h0, 32'h1234_5678, 32'h0, 1'b0, EO_LAT); consume("post_rst_mul0");
        do_op("post_rst_mul",  3'd0, 32'h55, 32'h3, 32'hFF, 1'b0, FULL); consume("post_rst_mul");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_riscv.md
MDU_RISCV -- requirements
Module: mdu_riscv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, 8..64).
REQ-002 SHALL have ports in this order:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: valid_i in 1 request valid; ready_o out 1 unit can accept.
REQ-004 SHALL have ports: op_i in 3 RISC-V M funct3 (0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU).
REQ-005 SHALL have ports: a_i in XLEN rs1 operand; b_i in XLEN rs2 operand.
REQ-006 SHALL have ports: kill_i in 1 pipeline flush; valid_o out 1 result valid; ready_i in 1 consumer accepts result.
REQ-007 SHALL have ports: result_o out XLEN result; dz_o out 1 divide-by-zero flag, qualified by valid_o.

Function
REQ-008 SHALL use three states: IDLE, CALC, DONE.
REQ-009 SHALL drive ready_o high only in IDLE.
REQ-010 SHALL accept a request on a rising edge with valid_i && ready_o && !kill_i, latching op_i, a_i and b_i.
REQ-011 SHALL otherwise go IDLE->CALC on accept, and SHALL ignore input changes after accept.
REQ-012 SHALL compute multiply as iterative shift-add over 2*XLEN-bit product, one bit per cycle, XLEN CALC cycles; MUL returns low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits with signed x signed, signed x unsigned, unsigned x unsigned operands respectively.
REQ-013 SHALL compute divide as restoring division on operand magnitudes, one quotient bit per cycle, XLEN CALC cycles, then sign-correct: quotient negative iff signs differ, remainder takes dividend sign.
REQ-014 SHALL assert valid_o exactly XLEN+1 rising edges after the accepting edge for normal operations.
REQ-015 SHALL, for DIV/DIVU/REM/REMU with b=0, skip CALC, enter DONE on the edge after accept, return quotient all-ones or remainder = a, and set dz_o=1.
REQ-016 SHALL, for DIV/REM with a = most-negative and b = -1, skip CALC: quotient = a, remainder = 0, dz_o=0, same 1-edge latency.
REQ-017 SHALL hold result_o, dz_o and valid_o stable in DONE until ready_i=1, then return to IDLE on that edge.
REQ-018 SHALL, with kill_i=1 on any edge, force state IDLE and valid_o=0 on that edge, discarding any operation; kill_i dominates valid_i and ready_i.
REQ-019 SHALL keep dz_o=0 for all multiply operations.
REQ-020 SHALL not accept a new request in the same edge a DONE result is consumed; ready_o rises one cycle later.

Reset
REQ-021 SHALL, on rst_n low, immediately set state IDLE, valid_o=0, result_o=0, dz_o=0 and internal counter/accumulators to 0, including mid-CALC.
REQ-022 SHALL drive ready_o=1 while reset is low and after release.

Configuration
REQ-023 SHALL honour macro MDU_EARLY_OUT_EN.
- Defined: MUL/MULHU/MULH/MULHSU with either operand zero, and DIVU/REMU with a_i < b_i unsigned, SHALL skip CALC and reach DONE one edge after accept with the correct result (0, or quotient 0 / remainder a).
- Undefined: these cases SHALL take the full XLEN+1 latency with identical results.

Verification
REQ-024 SHALL cover MUL: XLEN=32, a=0x0000_0007, b=0xFFFF_FFFD (MUL) -> result 0xFFFF_FFEB, valid_o at accept+33 edges; MULH same operands -> 0xFFFF_FFFF; MULHU -> 0x0000_0006.
REQ-025 SHALL cover DIV: a=-20 (0xFFFF_FFEC), b=3 -> DIV 0xFFFF_FFFA, REM 0xFFFF_FFFE; DIVU 20/3 -> 6, REMU -> 2.
REQ-026 SHALL cover divide by zero: DIV a=0x1234, b=0 -> result 0xFFFF_FFFF, dz_o=1, valid_o at accept+1 edge; REMU a=0x1234, b=0 -> 0x0000_1234.
REQ-027 SHALL cover overflow: DIV a=0x8000_0000, b=0xFFFF_FFFF -> 0x8000_0000; REM -> 0, accept+1 latency.
REQ-028 SHALL cover backpressure and kill: ready_i low 5 cycles after valid_o -> result stable, ready_o low; kill_i pulse mid-CALC (cycle 10) -> IDLE next edge, valid_o never asserts, next request correct.
REQ-029 SHALL cover reset during CALC: rst_n low at cycle 12 -> all outputs reset asynchronously, ready_o=1; run once with and once without MDU_EARLY_OUT_EN (MUL a=0 -> latency 1 vs 33).
